// File: rtl/stft_v1_my_system_path_join.sv
// rtl/stft_v1_my_system_path_join.sv - packs a stream of path components into one separator-joined string word
module stft_v1_my_system_path_join #(
  parameter int          MAX_BYTES = 512,
  parameter logic [7:0]  SEP       = 8'h2F,
  parameter int          LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  input  logic                   in_final,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*MAX_BYTES-1:0] out_path,
  output logic [LW-1:0]          out_len,
  output logic                   out_overflow
);

  typedef enum logic [1:0] {S_ACC, S_SEP, S_EMIT} state_t;

  state_t                 state;
  logic [8*MAX_BYTES-1:0] buffer;
  logic [LW-1:0]          wr_ptr;
  logic                   ovf;

  logic       accept;
  logic       full;
  logic       do_write;
  logic [7:0] wr_byte;

  // in_ready is forced low while reset is held so no byte is taken during reset
  assign in_ready = (state == S_ACC) && !rst;
  assign accept   = in_valid && in_ready;
  assign full     = (wr_ptr == LW'(MAX_BYTES));

  always_comb begin
    do_write = 1'b0;
    wr_byte  = in_data;
    if (state == S_SEP) begin
      do_write = 1'b1;
      wr_byte  = SEP;
    end else if (accept) begin
      do_write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ACC;
      wr_ptr <= '0;
      buffer <= '0;
      ovf    <= 1'b0;
    end else begin
      // writes at a full buffer are dropped but still consumed, so input never stalls
      if (do_write) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (wr_ptr == LW'(i)) buffer[8*i +: 8] <= wr_byte;
          end
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      case (state)
        S_ACC: begin
          if (accept && in_last) state <= in_final ? S_EMIT : S_SEP;
        end
        S_SEP: begin
          state <= S_ACC;
        end
        S_EMIT: begin
          if (out_ready) begin
            state  <= S_ACC;
            wr_ptr <= '0;
            buffer <= '0;
            ovf    <= 1'b0;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

  assign out_valid    = (state == S_EMIT);
  assign out_path     = buffer;
  assign out_len      = wr_ptr;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_stft_v1_my_system_path_join.sv
// tb/tb_stft_v1_my_system_path_join.sv - scoreboard bench driving a full-size and a 4-byte instance in lockstep
module tb_stft_v1_my_system_path_join;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_final;
  logic         out_ready;

  logic         b_ready, b_valid, b_ovf;
  logic [4095:0] b_path;
  logic [9:0]   b_len;
  logic         s_ready, s_valid, s_ovf;
  logic [31:0]  s_path;
  logic [2:0]   s_len;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4095:0] path;
    int            len;
    logic          ovf;
  } exp_t;

  exp_t q_b[$];
  exp_t q_s[$];

  always #5 clk = ~clk;

  stft_v1_my_system_path_join dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data),
    .in_last(in_last), .in_final(in_final), .out_valid(b_valid), .out_ready(out_ready),
    .out_path(b_path), .out_len(b_len), .out_overflow(b_ovf)
  );

  stft_v1_my_system_path_join #(.MAX_BYTES(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data),
    .in_last(in_last), .in_final(in_final), .out_valid(s_valid), .out_ready(out_ready),
    .out_path(s_path), .out_len(s_len), .out_overflow(s_ovf)
  );

  task automatic chk(string tag, logic [4095:0] obs, logic [4095:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // '|' in the stimulus string marks a component boundary; joined text uses '/'
  function automatic exp_t model(string p, int cap);
    exp_t e;
    int   n = 0;
    e.path = '0;
    for (int i = 0; i < p.len(); i++) begin
      logic [7:0] c;
      c = p[i];
      if (c == 8'h7C) c = 8'h2F;
      if (n < cap) e.path[8*n +: 8] = c;
      n++;
    end
    e.len = (n > cap) ? cap : n;
    e.ovf = (n > cap);
    return e;
  endfunction

  task automatic send_byte(logic [7:0] d, logic l, logic f);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; in_final = f;
    while (!b_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", b_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0; in_final = 1'b0;
  endtask

  task automatic check_out(string tag, exp_t eb, exp_t es);
    chk({tag, "_b_valid"}, b_valid, 1);
    chk({tag, "_b_path"}, b_path, eb.path);
    chk({tag, "_b_len"}, b_len, eb.len);
    chk({tag, "_b_ovf"}, b_ovf, eb.ovf);
    chk({tag, "_s_valid"}, s_valid, 1);
    chk({tag, "_s_path"}, s_path, es.path);
    chk({tag, "_s_len"}, s_len, es.len);
    chk({tag, "_s_ovf"}, s_ovf, es.ovf);
    chk({tag, "_in_ready"}, {b_ready, s_ready}, 0);
  endtask

  task automatic receive(int hold);
    exp_t eb, es;
    eb = q_b.pop_front();
    es = q_s.pop_front();
    @(negedge clk);
    check_out("emit", eb, es);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_out("hold", eb, es);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", {b_valid, s_valid}, 0);
    chk("post_ready", {b_ready, s_ready}, 2'b11);
    chk("post_b_path", b_path, 0);
    chk("post_s_path", s_path, 0);
    chk("post_len", {b_len, s_len}, 0);
    chk("post_ovf", {b_ovf, s_ovf}, 0);
  endtask

  task automatic send_path(string p, int hold);
    q_b.push_back(model(p, 512));
    q_s.push_back(model(p, 4));
    for (int i = 0; i < p.len(); i++) begin
      logic l, f;
      if (p[i] == 8'h7C) continue;
      f = (i + 1 == p.len());
      l = f || (p[i+1] == 8'h7C);
      send_byte(p[i], l, f);
      if (l && !f) begin
        @(negedge clk);
        chk("sep_bubble_low", {b_ready, s_ready}, 0);
        @(negedge clk);
        chk("sep_bubble_high", {b_ready, s_ready}, 2'b11);
      end
    end
    receive(hold);
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_valid"}, {b_valid, s_valid}, 0);
    chk({tag, "_b_path"}, b_path, 0);
    chk({tag, "_s_path"}, s_path, 0);
    chk({tag, "_len"}, {b_len, s_len}, 0);
    chk({tag, "_ovf"}, {b_ovf, s_ovf}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_final = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_in_ready", {b_ready, s_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_ready", {b_ready, s_ready}, 2'b11);

    send_path("abc", 0);
    send_path("ab|cd", 0);
    send_path("abcdef", 10);
    send_path("x", 0);
    send_path("abcd|e", 0);

    // abort a path by resetting during its separator cycle
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset");
    chk("midreset_ready", {b_ready, s_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_novalid", {b_valid, s_valid}, 0);
    chk("midreset_ready_back", {b_ready, s_ready}, 2'b11);
    send_path("z", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
